// File: rtl/bus_dma.sv
// Sprite DMA: a CPU write to TRIG_ADDR stalls the core and copies XFER_LEN bytes from
// RAM page {cpu_out, 8'hxx} to the destination port. Define BUS_DMA_BURST_EN for the overlapped mode.
module bus_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter int unsigned XFER_LEN  = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic        cpu_ce,
  output logic [15:0] mem_address,
  input  logic [7:0]  mem_in,
  output logic [7:0]  mem_out,
  output logic        mem_we,
  output logic [7:0]  dst_address,
  output logic [7:0]  dst_data,
  output logic        dst_we,
  output logic        busy
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StDrain, StResume} state_e;

  localparam logic [8:0] LastIdx = 9'(XFER_LEN - 1);

  state_e      state_q;
  logic [7:0]  page_q;
  logic [8:0]  index_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      index_q <= 9'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_we && (cpu_address == TRIG_ADDR)) begin
            page_q  <= cpu_out;
            index_q <= 9'd0;
            state_q <= StRead;
          end
        end
`ifdef BUS_DMA_BURST_EN
        // index_q counts reads; the write lags one byte behind
        StRead: begin
          index_q <= index_q + 9'd1;
          if (index_q == LastIdx) state_q <= StDrain;
        end
        StDrain:  state_q <= StIdle;
`else
        StRead:   state_q <= StWrite;
        StWrite: begin
          if (index_q == LastIdx) begin
            state_q <= StResume;
          end else begin
            index_q <= index_q + 9'd1;
            state_q <= StRead;
          end
        end
`endif
        StResume: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode state only; cpu_ce never depends on cpu_* inputs
  always_comb begin
    mem_address = cpu_address;
    mem_out     = cpu_out;
    mem_we      = 1'b0;
    cpu_ce      = 1'b0;
    busy        = 1'b1;
    dst_we      = 1'b0;
    dst_address = index_q[7:0];
    dst_data    = mem_in;
    unique case (state_q)
      StIdle: begin
        mem_we = cpu_we;
        cpu_ce = 1'b1;
        busy   = 1'b0;
      end
      StRead: begin
        mem_address = {page_q, index_q[7:0]};
`ifdef BUS_DMA_BURST_EN
        dst_we      = (index_q != 9'd0);
        dst_address = index_q[7:0] - 8'd1;
`endif
      end
      StWrite: dst_we = 1'b1;
      StDrain: begin
        dst_we      = 1'b1;
        dst_address = index_q[7:0] - 8'd1;
      end
      StResume: ;
      default: ;
    endcase
  end

endmodule
